// File: rtl/down_cnt_arbiter_pkg.sv
// Shared definitions for the two-requester down-counter arbiter.
package down_cnt_arbiter_pkg;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_RST = 8'hFF;

    // 2'b11 is unused and behaves as IDLE wherever it is decoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Requester index to one-hot grant vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/down_cnt_core.sv
// Loadable down-counter datapath shared by both requesters.
// Load takes priority over decrement; the arbiter guarantees dec never
// fires at zero, so there is no wrap protection here.
module down_cnt_core
    import down_cnt_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         is_one
);

    logic [W-1:0] cnt_q;

    // Counter register: reset to all-ones, load wins over decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= W'(CNT_RST);
        end else if (load) begin
            cnt_q <= din;
        end else if (dec) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign dout   = cnt_q;
    assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/down_cnt_arbiter.sv
// Round-robin arbiter that lends one down-counter to two requesters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate on any request and load the winner's length
// RUN   | counting down for the granted requester (hold freezes, drop aborts)
// DONE  | single-cycle completion; done pulses to the granted requester
module down_cnt_arbiter
    import down_cnt_arbiter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             hold,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             winner;
    logic [WIDTH-1:0] len_sel;
    logic             load, dec, is_one;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        winner = (req == 2'b11) ? ~last_q : req[1];
        len_sel = winner ? len1 : len0;
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and counter control. Abort is checked before hold and
    // before the final decrement so a dropped request never sees done.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if ((req & gnt_q) == 2'b00) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end else if (!hold) begin
                    dec = 1'b1;
                    if (is_one) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                if (req != 2'b00) begin
                    load    = 1'b1;
                    gnt_d   = onehot2(winner);
                    last_d  = winner;
                    state_d = (len_sel != '0) ? ST_RUN : ST_DONE;
                end
            end
        endcase
    end

    down_cnt_core #(
        .W (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .dec     (dec),
        .din     (len_sel),
        .dout    (count),
        .is_one  (is_one)
    );

    assign gnt  = gnt_q;
    assign done = gnt_q & {2{state_q == ST_DONE}};
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_down_cnt_arbiter.sv
module tb_down_cnt_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] len0 = 8'd0;
    logic [7:0] len1 = 8'd0;
    logic       hold = 1'b0;
    logic [1:0] gnt, done;
    logic       busy;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;

    down_cnt_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .hold    (hold),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Sampling and driving both happen at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = 2'b00; hold = 1'b0;
        step(); step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b00; hold = 1'b0;
        step(); step();
        checks++; if (count !== 8'hFF) begin failures++; $display("FAIL reset_count got=%h exp=ff", count); end
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        step();
        checks++; if (count !== 8'hFF || busy !== 1'b0) begin failures++; $display("FAIL idle_no_req count=%h busy=%b exp ff/0", count, busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_cnt [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
        logic [1:0] exp_dn  [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        req = 2'b01; len0 = 8'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            len0 = 8'd99;
            checks++;
            if (count !== exp_cnt[i] || gnt !== 2'b01 || done !== exp_dn[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_c%0d count=%0d gnt=%b done=%b busy=%b exp %0d/01/%b/1",
                         i, count, gnt, done, busy, exp_cnt[i], exp_dn[i]);
            end
        end
        req = 2'b00;
        step();
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00 || count !== 8'd0) begin
            failures++;
            $display("FAIL single_end busy=%b gnt=%b done=%b count=%0d exp 0/00/00/0", busy, gnt, done, count);
        end
    endtask

    task automatic test_tie();
        logic [7:0] exp_c1 [5] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        apply_reset();
        req = 2'b11; len0 = 8'd2; len1 = 8'd4;
        step();
        checks++; if (gnt !== 2'b01 || count !== 8'd2) begin failures++; $display("FAIL tie_first gnt=%b count=%0d exp 01/2", gnt, count); end
        step();
        checks++; if (count !== 8'd1 || done !== 2'b00) begin failures++; $display("FAIL tie_r0_mid count=%0d done=%b exp 1/00", count, done); end
        step();
        checks++; if (count !== 8'd0 || done !== 2'b01) begin failures++; $display("FAIL tie_r0_done count=%0d done=%b exp 0/01", count, done); end
        req = 2'b10;
        step();
        checks++; if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL tie_gap gnt=%b busy=%b done=%b exp 00/0/00", gnt, busy, done); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gnt !== 2'b10 || count !== exp_c1[i] || done !== ((i == 4) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL tie_r1_c%0d gnt=%b count=%0d done=%b exp 10/%0d", i, gnt, count, done, exp_c1[i]);
            end
        end
        req = 2'b11;
        step();
        checks++; if (gnt !== 2'b00 || done !== 2'b00) begin failures++; $display("FAIL tie_gap2 gnt=%b done=%b exp 00/00", gnt, done); end
        step();
        checks++; if (gnt !== 2'b01 || count !== 8'd2) begin failures++; $display("FAIL tie_rr gnt=%b count=%0d exp 01/2", gnt, count); end
        req = 2'b00;
        step();
        checks++; if (busy !== 1'b0 || count !== 8'd2 || done !== 2'b00) begin failures++; $display("FAIL tie_abort busy=%b count=%0d done=%b exp 0/2/00", busy, count, done); end
    endtask

    task automatic test_zero_len();
        req = 2'b01; len0 = 8'd0;
        step();
        checks++;
        if (gnt !== 2'b01 || done !== 2'b01 || count !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_len gnt=%b done=%b count=%0d busy=%b exp 01/01/0/1", gnt, done, count, busy);
        end
        req = 2'b00;
        step();
        checks++; if (busy !== 1'b0 || done !== 2'b00 || count !== 8'd0) begin failures++; $display("FAIL zero_end busy=%b done=%b count=%0d exp 0/00/0", busy, done, count); end
    endtask

    task automatic test_hold();
        logic [7:0] exp_cnt [9] = '{8'd5, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        req = 2'b10; len1 = 8'd5;
        for (int i = 0; i < 9; i++) begin
            step();
            hold = (i >= 1 && i <= 3);
            checks++;
            if (count !== exp_cnt[i] || gnt !== 2'b10 || done !== ((i == 8) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL hold_c%0d count=%0d gnt=%b done=%b exp %0d/10", i, count, gnt, done, exp_cnt[i]);
            end
        end
        hold = 1'b0; req = 2'b00;
        step();
        checks++; if (busy !== 1'b0 || gnt !== 2'b00) begin failures++; $display("FAIL hold_end busy=%b gnt=%b exp 0/00", busy, gnt); end
    endtask

    task automatic test_abort();
        req = 2'b01; len0 = 8'd10;
        for (int i = 0; i < 5; i++) step();
        checks++; if (count !== 8'd6 || gnt !== 2'b01) begin failures++; $display("FAIL abort_pre count=%0d gnt=%b exp 6/01", count, gnt); end
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || gnt !== 2'b00 || count !== 8'd6 || done !== 2'b00) begin
                failures++;
                $display("FAIL abort_c%0d busy=%b gnt=%b count=%0d done=%b exp 0/00/6/00", i, busy, gnt, count, done);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 2'b01; len0 = 8'd200;
        step();
        for (int i = 0; i < 80; i++) step();
        checks++; if (count !== 8'd120) begin failures++; $display("FAIL areset_pre count=%0d exp 120", count); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'hFF || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_async count=%h gnt=%b done=%b busy=%b exp ff/00/00/0", count, gnt, done, busy);
        end
        step();
        reset_n = 1'b1;
        req = 2'b11; len0 = 8'd7; len1 = 8'd9;
        step();
        checks++; if (gnt !== 2'b01 || count !== 8'd7) begin failures++; $display("FAIL areset_tie gnt=%b count=%0d exp 01/7", gnt, count); end
        req = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_zero_len();
        test_hold();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/down_cnt_arbiter.md
Name: down_cnt_arbiter

Overview:
- Shares one 8-bit down-counter datapath between two requesters.
- Each requester asks for a countdown of a programmable length.
- The block arbitrates round-robin, loads the granted length into the counter, and sequences the decrement to zero.
- It signals completion to the winner with a done pulse. It sits between client logic and the down-counter core.

Parameters:
- WIDTH, 8, counter and length width (verification targets 8 only)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  2  per-requester request, level; held until own done or deliberately dropped (abort)
- len0  input  WIDTH  countdown length for requester 0, sampled at grant edge only
- len1  input  WIDTH  countdown length for requester 1, sampled at grant edge only
- hold  input  1  freeze: counter and FSM hold while high in RUN
- gnt  output  2  one-hot grant, registered
- done  output  2  one-cycle completion pulse to granted requester
- busy  output  1  high whenever state != IDLE
- count  output  WIDTH  live counter value

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, count=8'hFF, gnt=2'b00, done=2'b00, busy=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- IDLE:
  - No req: nothing changes; count holds its last value.
  - Any req at edge E0: pick the winner. Single request wins outright. On req=2'b11, the requester != last wins.
  - At E0: gnt<=onehot(winner), last<=winner, count<=len_winner.
  - At E0: state<=RUN if len!=0; state<=DONE if len==0.
- RUN:
  - Every edge with hold=0 and req[g]=1: count<=count-1.
  - When count==1 at the edge, count becomes 0 and state<=DONE.
  - For length L>=1, done asserts in the cycle following edge E0+L. L=255 takes 255 decrements; no wrap ever occurs.
  - hold=1: count and state frozen. hold is ignored in IDLE and DONE.
  - req[g] deasserted (abort): next edge state<=IDLE, gnt<=0, count holds, no done pulse. Abort has priority over hold and over the final decrement.
- DONE:
  - Lasts exactly one cycle; done[g]=1 and gnt[g] still 1.
  - Next edge: state<=IDLE, gnt<=0.
  - The requester drops req during DONE or is eligible again next IDLE cycle.
- done = gnt & {2{state==DONE}}, decoded from registers. It is never high for a non-granted requester.
- Requests from the non-granted requester while busy are ignored; it must keep req high to be served.
- Arbitration happens only in IDLE, so back-to-back service has one IDLE cycle between grants.
- Reset mid-operation: immediate return to reset values; no done pulse.
- len inputs are don't-care except at the grant edge.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 decodes to IDLE.
  - Width constant CNT_W=8.
  - Reset constant CNT_RST=8'hFF.
- Sub-module down_cnt_core:
  - Ports: clk, reset_n, load, dec, din[7:0], dout[7:0], is_one.
  - Async active-low reset to 8'hFF; load has priority over dec.
  - Arbiter FSM and round-robin pointer live in the top.

Test Plan:
- After reset: count=8'hFF, gnt=0, done=0, busy=0. Then req=2'b01, len0=3 -> gnt=01 after next edge; count goes 3,2,1,0; done=01 for exactly one cycle; then busy=0.
- req=2'b11 from reset, len0=2, len1=4 -> requester 0 served first. Keep req1 high -> after one IDLE cycle gnt=10, count=4..0, done=10. Next tie goes to requester 0.
- len0=0 -> grant edge goes straight to DONE: done=01 one cycle after the grant edge, count=0, no decrement.
- len1=5, hold=1 for 3 cycles mid-RUN -> count frozen at its value for 3 cycles; done delayed by exactly 3 cycles.
- len0=10, req0 dropped when count=6 -> next edge IDLE, gnt=0, count stays 6, done never asserts.
- len0=200, reset_n pulsed low while count=120 -> asynchronously count=8'hFF, gnt=0, done=0, busy=0; the next tie after reset grants requester 0.
